// File: rtl/dma_pkg.sv
// dma_pkg: shared AHB/DMA types and burst helpers for the DMA burst sequencer.
package dma_pkg;
   typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HWORD = 2'd1, SZ_WORD = 2'd2} size_t;
   typedef enum logic [1:0] {BR_SINGLE = 2'd0, BR_INC4 = 2'd1, BR_INC8 = 2'd2, BR_INC16 = 2'd3} burst_t;
   typedef enum logic [1:0] {HT_IDLE = 2'd0, HT_BUSY = 2'd1, HT_NONSEQ = 2'd2, HT_SEQ = 2'd3} htrans_t;
   typedef enum logic [2:0] {HB_SINGLE = 3'd0, HB_INCR4 = 3'd3, HB_INCR8 = 3'd5, HB_INCR16 = 3'd7} hburst_t;
   localparam int BOUNDARY_1K = 1024;
   function automatic logic [4:0] burst_len(input burst_t b);
      return b == BR_INC16 ? 5'd16 : b == BR_INC8 ? 5'd8 : b == BR_INC4 ? 5'd4 : 5'd1;
   endfunction
   function automatic hburst_t burst_to_hburst(input burst_t b);
      return b == BR_INC16 ? HB_INCR16 : b == BR_INC8 ? HB_INCR8 : b == BR_INC4 ? HB_INCR4 : HB_SINGLE;
   endfunction
endpackage

// File: rtl/dma_burst_planner.sv
// dma_burst_planner: picks the effective burst length/HBURST, falling back to SINGLE
// when too few items remain, the address is fixed, or the burst would cross 1 KB.
module dma_burst_planner
   import dma_pkg::*;
#(
   parameter int addr_w = 32,
   parameter int ndt_w  = 18
) (
   input  logic [addr_w-1:0] addr_i,
   input  logic              inc_i,
   input  size_t             size_i,
   input  burst_t            burst_i,
   input  logic [ndt_w-1:0]  rem_i,
   output logic [4:0]        len_o,
   output hburst_t           hburst_o
);
   logic [4:0] len;
   logic [addr_w-1:0] off, span;
   logic single;
   always_comb begin
      len = burst_len(burst_i);
      off = addr_i & addr_w'(BOUNDARY_1K - 1);
      span = addr_w'(len) << size_i;
      single = !inc_i || rem_i < ndt_w'(len) || off + span > addr_w'(BOUNDARY_1K);
      len_o = single ? 5'd1 : len;
      hburst_o = single ? HB_SINGLE : burst_to_hburst(burst_i);
   end
endmodule

// File: rtl/dma_burst_sequencer.sv
// dma_burst_sequencer: issues AHB-Lite address phases for the granted DMA stream and
// tracks data-phase completion, counting NDT down and flagging beat/burst/done/error events.
module dma_burst_sequencer
   import dma_pkg::*;
#(
   parameter int addr_w = 32,
   parameter int ndt_w  = 18
) (
   input  logic              i_clk,
   input  logic              i_nreset,
   input  logic              i_load,
   input  logic              i_en,
   input  logic [addr_w-1:0] i_addr,
   input  logic              i_inc,
   input  logic [1:0]        i_size,
   input  logic [1:0]        i_burst,
   input  logic [ndt_w-1:0]  i_ndt,
   input  logic              i_hready,
   input  logic              i_hresp,
   output logic [1:0]        o_htrans,
   output logic [addr_w-1:0] o_haddr,
   output logic [2:0]        o_hsize,
   output logic [2:0]        o_hburst,
   output logic [ndt_w-1:0]  o_ndt,
   output logic              o_beat_done,
   output logic              o_burst_end,
   output logic              o_done,
   output logic              o_busy,
   output logic              o_err
);
   typedef enum logic [1:0] {st_idle, st_ready, st_burst, st_err} state_t;
   state_t state_q, state_d;
   htrans_t htrans_q, htrans_d;
   hburst_t hburst_q, hburst_d, p_hburst;
   size_t size_q, size_d;
   burst_t burst_q, burst_d;
   logic [addr_w-1:0] addr_q, addr_d, addr_n;
   logic [ndt_w-1:0] ndt_q, ndt_d, rem_q, rem_d, rem_n;
   logic [4:0] beat_q, beat_d, len_q, len_d, p_len;
   logic inc_q, inc_d, pend_q, pend_d, err_q, err_d;
   logic beat_done_q, beat_done_d, burst_end_q, burst_end_d, done_q, done_d;
   logic ld, acc, cpl, plan;
   assign o_busy = state_q == st_ready || state_q == st_burst || pend_q;
   assign ld  = i_load && !o_busy;
   assign acc = htrans_q != HT_IDLE && i_hready;
   assign cpl = pend_q && i_hready && !i_hresp;
   // address/remaining count as they will be after this cycle's acceptance
   assign addr_n = acc && inc_q ? addr_q + (addr_w'(1) << size_q) : addr_q;
   assign rem_n  = acc ? rem_q - ndt_w'(1) : rem_q;
   dma_burst_planner #(.addr_w(addr_w), .ndt_w(ndt_w)) u_planner (
      .addr_i  (ld ? i_addr : addr_n),
      .inc_i   (ld ? i_inc : inc_q),
      .size_i  (ld ? size_t'(i_size) : size_q),
      .burst_i (ld ? burst_t'(i_burst) : burst_q),
      .rem_i   (ld ? i_ndt : rem_n),
      .len_o   (p_len),
      .hburst_o(p_hburst)
   );
   always_comb begin
      state_d = state_q;
      htrans_d = htrans_q;
      hburst_d = hburst_q;
      size_d = size_q;
      burst_d = burst_q;
      inc_d = inc_q;
      addr_d = addr_n;
      rem_d = rem_n;
      ndt_d = cpl ? ndt_q - ndt_w'(1) : ndt_q;
      beat_d = beat_q;
      len_d = len_q;
      err_d = err_q;
      pend_d = acc || (pend_q && !i_hready);
      beat_done_d = cpl;
      burst_end_d = 1'b0;
      done_d = 1'b0;
      plan = 1'b0;
      if (ld) begin
         addr_d = i_addr;
         inc_d = i_inc;
         size_d = size_t'(i_size);
         burst_d = burst_t'(i_burst);
         ndt_d = i_ndt;
         rem_d = i_ndt;
         err_d = 1'b0;
         state_d = i_ndt == '0 ? st_idle : st_ready;
         plan = i_ndt != '0 && i_en;
      end else if (pend_q && i_hresp && !i_hready && !err_q) begin
         // first ERROR cycle: cancel whatever address phase is on the bus
         htrans_d = HT_IDLE;
         err_d = 1'b1;
         state_d = st_err;
      end else if (cpl && ndt_q == ndt_w'(1)) begin
         done_d = 1'b1;
         state_d = st_idle;
      end else if (state_q == st_ready) begin
         plan = i_en && rem_q != '0;
      end else if (state_q == st_burst && acc) begin
         if (beat_q == len_q - 5'd1) begin
            burst_end_d = 1'b1;
            plan = i_en && rem_n != '0;
            htrans_d = HT_IDLE;
            state_d = st_ready;
         end else begin
            htrans_d = HT_SEQ;
            beat_d = beat_q + 5'd1;
         end
      end
      if (plan) begin
         htrans_d = HT_NONSEQ;
         hburst_d = p_hburst;
         len_d = p_len;
         beat_d = '0;
         state_d = st_burst;
      end
   end
   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         state_q <= st_idle;
         htrans_q <= HT_IDLE;
         hburst_q <= HB_SINGLE;
         size_q <= SZ_BYTE;
         burst_q <= BR_SINGLE;
         inc_q <= 1'b0;
         addr_q <= '0;
         rem_q <= '0;
         ndt_q <= '0;
         beat_q <= '0;
         len_q <= '0;
         err_q <= 1'b0;
         pend_q <= 1'b0;
         beat_done_q <= 1'b0;
         burst_end_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         htrans_q <= htrans_d;
         hburst_q <= hburst_d;
         size_q <= size_d;
         burst_q <= burst_d;
         inc_q <= inc_d;
         addr_q <= addr_d;
         rem_q <= rem_d;
         ndt_q <= ndt_d;
         beat_q <= beat_d;
         len_q <= len_d;
         err_q <= err_d;
         pend_q <= pend_d;
         beat_done_q <= beat_done_d;
         burst_end_q <= burst_end_d;
         done_q <= done_d;
      end
   end
   assign o_htrans = htrans_q;
   assign o_haddr = addr_q;
   assign o_hsize = {1'b0, size_q};
   assign o_hburst = hburst_q;
   assign o_ndt = ndt_q;
   assign o_beat_done = beat_done_q;
   assign o_burst_end = burst_end_q;
   assign o_done = done_q;
   assign o_err = err_q;
endmodule

// File: tb/tb_dma_burst_sequencer.sv
// tb_dma_burst_sequencer: directed bench with a queue of expected address phases
// built from an independent burst-splitting model and checked as beats are accepted.
module tb_dma_burst_sequencer;
   logic i_clk = 1'b0, i_nreset = 1'b0, i_load = 1'b0, i_en = 1'b0, i_inc = 1'b0;
   logic i_hready = 1'b0, i_hresp = 1'b0;
   logic [31:0] i_addr = '0;
   logic [1:0] i_size = '0, i_burst = '0;
   logic [17:0] i_ndt = '0;
   logic [1:0] o_htrans;
   logic [31:0] o_haddr;
   logic [2:0] o_hsize, o_hburst;
   logic [17:0] o_ndt;
   logic o_beat_done, o_burst_end, o_done, o_busy, o_err;
   typedef struct packed {logic [31:0] addr; logic [1:0] htrans; logic [2:0] hburst;} beat_t;
   beat_t exp_q[$];
   beat_t mon_e;
   int n_pass = 0, n_total = 0, n_bd = 0, n_be = 0, n_acc = 0;
   int bd0, be0, acc0;
   dma_burst_sequencer dut (
      .i_clk(i_clk), .i_nreset(i_nreset), .i_load(i_load), .i_en(i_en), .i_addr(i_addr),
      .i_inc(i_inc), .i_size(i_size), .i_burst(i_burst), .i_ndt(i_ndt), .i_hready(i_hready),
      .i_hresp(i_hresp), .o_htrans(o_htrans), .o_haddr(o_haddr), .o_hsize(o_hsize),
      .o_hburst(o_hburst), .o_ndt(o_ndt), .o_beat_done(o_beat_done), .o_burst_end(o_burst_end),
      .o_done(o_done), .o_busy(o_busy), .o_err(o_err)
   );
   always #5 i_clk = ~i_clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask
   task automatic plan_exp(input logic [31:0] a0, input logic inc, input int sz, input int bu, input int ndt);
      logic [31:0] a;
      int rem, l;
      a = a0;
      rem = ndt;
      while (rem > 0) begin
         l = bu == 0 ? 1 : bu == 1 ? 4 : bu == 2 ? 8 : 16;
         if (rem < l || !inc || (a % 1024) + (l << sz) > 1024) l = 1;
         for (int k = 0; k < l; k++) begin
            exp_q.push_back(beat_t'{addr: a, htrans: k == 0 ? 2'd2 : 2'd3,
               hburst: l == 1 ? 3'd0 : l == 4 ? 3'd3 : l == 8 ? 3'd5 : 3'd7});
            if (inc) a += 32'(1 << sz);
            rem--;
         end
      end
   endtask
   task automatic load(input logic [31:0] a, input logic inc, input int sz, input int bu, input int ndt);
      plan_exp(a, inc, sz, bu, ndt);
      bd0 = n_bd;
      be0 = n_be;
      acc0 = n_acc;
      i_addr = a;
      i_inc = inc;
      i_size = 2'(sz);
      i_burst = 2'(bu);
      i_ndt = 18'(ndt);
      i_load = 1'b1;
      tick;
      i_load = 1'b0;
   endtask
   task automatic wait_done(input string tag, input int ndt, input int bends);
      int c;
      c = 0;
      while (o_done !== 1'b1 && c < 200) begin
         tick;
         c++;
      end
      check({tag, "_done"}, 32'(o_done), 1);
      check({tag, "_ndt_zero"}, 32'(o_ndt), 0);
      check({tag, "_busy_clear"}, 32'(o_busy), 0);
      tick;
      check({tag, "_done_pulse"}, 32'(o_done), 0);
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 0);
      check({tag, "_beat_done_cnt"}, 32'(n_bd - bd0), 32'(ndt));
      check({tag, "_burst_end_cnt"}, 32'(n_be - be0), 32'(bends));
   endtask
   always @(negedge i_clk) begin
      if (i_nreset) begin
         if (o_beat_done) n_bd++;
         if (o_burst_end) n_be++;
         if (o_htrans != 2'd0 && i_hready) begin
            n_acc++;
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               check("beat_haddr", o_haddr, mon_e.addr);
               check("beat_htrans", 32'(o_htrans), 32'(mon_e.htrans));
               check("beat_hburst", 32'(o_hburst), 32'(mon_e.hburst));
            end else check("extra_beat", 32'(o_htrans), 0);
         end
      end
   end
   initial begin
      repeat (2) tick;
      check("rst_htrans", 32'(o_htrans), 0);
      check("rst_haddr", o_haddr, 0);
      check("rst_ndt", 32'(o_ndt), 0);
      check("rst_busy", 32'(o_busy), 0);
      check("rst_err", 32'(o_err), 0);
      check("rst_done", 32'(o_done), 0);
      i_nreset = 1'b1;
      i_en = 1'b1;
      i_hready = 1'b1;
      tick;
      load(32'h100, 1'b1, 2, 0, 3);
      check("t1_latency_htrans", 32'(o_htrans), 2);
      check("t1_latency_haddr", o_haddr, 32'h100);
      check("t1_hsize", 32'(o_hsize), 2);
      wait_done("t1", 3, 3);
      load(32'h200, 1'b1, 2, 1, 6);
      wait_done("t2", 6, 3);
      load(32'h3F8, 1'b1, 2, 1, 8);
      wait_done("t3", 8, 5);
      load(32'h500, 1'b0, 1, 2, 4);
      check("t4_hsize", 32'(o_hsize), 1);
      wait_done("t4", 4, 4);
      load(32'h600, 1'b1, 2, 1, 4);
      tick;
      i_hready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         check("t5_hold_htrans", 32'(o_htrans), 3);
         check("t5_hold_haddr", o_haddr, 32'h604);
         check("t5_hold_hburst", 32'(o_hburst), 3);
         check("t5_hold_ndt", 32'(o_ndt), 4);
      end
      check("t5_hold_beats", 32'(n_bd - bd0), 0);
      i_hready = 1'b1;
      wait_done("t5", 4, 1);
      load(32'h800, 1'b1, 2, 2, 16);
      repeat (2) tick;
      i_hready = 1'b0;
      i_hresp = 1'b1;
      tick;
      check("t6_err_idle", 32'(o_htrans), 0);
      check("t6_err_flag", 32'(o_err), 1);
      i_hready = 1'b1;
      tick;
      i_hresp = 1'b0;
      check("t6_err_ndt", 32'(o_ndt), 15);
      check("t6_err_busy", 32'(o_busy), 0);
      tick;
      check("t6_err_stay_idle", 32'(o_htrans), 0);
      check("t6_err_sticky", 32'(o_err), 1);
      check("t6_err_beats", 32'(n_acc - acc0), 2);
      check("t6_err_beat_done", 32'(n_bd - bd0), 1);
      exp_q.delete();
      load(32'h900, 1'b1, 2, 0, 1);
      check("t6_err_cleared", 32'(o_err), 0);
      wait_done("t6", 1, 1);
      load(32'hA00, 1'b1, 2, 1, 8);
      tick;
      i_en = 1'b0;
      repeat (3) tick;
      check("t7_burst_end", 32'(o_burst_end), 1);
      for (int k = 0; k < 3; k++) begin
         check("t7_en_low_idle", 32'(o_htrans), 0);
         tick;
      end
      check("t7_first_burst_beats", 32'(n_acc - acc0), 4);
      i_en = 1'b1;
      wait_done("t7", 8, 2);
      load(32'hC00, 1'b1, 2, 1, 0);
      tick;
      check("t8_ndt0_busy", 32'(o_busy), 0);
      check("t8_ndt0_htrans", 32'(o_htrans), 0);
      check("t8_ndt0_done", 32'(o_done), 0);
      load(32'hB00, 1'b1, 2, 1, 8);
      tick;
      i_nreset = 1'b0;
      #1;
      check("t9_rst_htrans", 32'(o_htrans), 0);
      check("t9_rst_ndt", 32'(o_ndt), 0);
      check("t9_rst_busy", 32'(o_busy), 0);
      tick;
      check("t9_rst_done", 32'(o_done), 0);
      exp_q.delete();
      i_nreset = 1'b1;
      tick;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
